// File: rtl/servo_track_pkg.sv
// Shared types and constants for the solar tracker sequencer: FSM states,
// servo direction codes and default pulse-width limits.
package servo_track_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ADC = 3'd2,
    DECIDE   = 3'd3,
    MOVE     = 3'd4,
    SETTLE   = 3'd5
  } state_t;

  // Same encoding as servo_driver's direction output.
  typedef enum logic [1:0] {
    STOP = 2'b00,
    CW   = 2'b01,
    CCW  = 2'b10
  } dir_t;

  localparam logic AXIS_H = 1'b0;
  localparam logic AXIS_V = 1'b1;

  localparam int unsigned DEF_POS_MIN = 500;
  localparam int unsigned DEF_POS_MAX = 2500;

  // A servo already at (or beyond) the end it would move towards cannot move.
  function automatic logic at_limit(input dir_t dir, input logic [31:0] pos,
                                    input logic [31:0] pos_min, input logic [31:0] pos_max);
    return ((dir == CCW) && (pos <= pos_min)) || ((dir == CW) && (pos >= pos_max));
  endfunction

endpackage

// File: rtl/servo_track_sched_decide.sv
// Combinational move decision: opposing-pair compare, deadband, axis pick and
// limit blocking. dir is STOP whenever move_ok is low.
module track_decide
  import servo_track_pkg::*;
#(
  parameter int          ADC_W    = 12,
  parameter int          DEADBAND = 64,
  parameter logic [31:0] POS_MIN  = DEF_POS_MIN,
  parameter logic [31:0] POS_MAX  = DEF_POS_MAX
) (
  input  logic [ADC_W-1:0] adc_top,
  input  logic [ADC_W-1:0] adc_bot,
  input  logic [ADC_W-1:0] adc_left,
  input  logic [ADC_W-1:0] adc_right,
  input  logic [31:0]      pos_h,
  input  logic [31:0]      pos_v,
  output logic             axis,
  output logic [1:0]       dir,
  output logic             move_ok
);

  localparam logic [ADC_W-1:0] DB = ADC_W'(DEADBAND);

  logic [ADC_W-1:0] mag_h;
  logic [ADC_W-1:0] mag_v;
  logic [ADC_W-1:0] mag_sel;
  dir_t             dir_h;
  dir_t             dir_v;
  dir_t             dir_sel;
  logic [31:0]      pos_sel;

  // Magnitudes are taken without a sign bit; the sign only picks the direction.
  always_comb begin
    mag_h   = (adc_left >= adc_right) ? (adc_left - adc_right) : (adc_right - adc_left);
    mag_v   = (adc_top >= adc_bot) ? (adc_top - adc_bot) : (adc_bot - adc_top);
    dir_h   = (adc_left > adc_right) ? CCW : CW;
    dir_v   = (adc_top > adc_bot) ? CCW : CW;
    axis    = (mag_h >= mag_v) ? AXIS_H : AXIS_V;
    mag_sel = (axis == AXIS_H) ? mag_h : mag_v;
    dir_sel = (axis == AXIS_H) ? dir_h : dir_v;
    pos_sel = (axis == AXIS_H) ? pos_h : pos_v;
    move_ok = (mag_sel > DB) && !at_limit(dir_sel, pos_sel, POS_MIN, POS_MAX);
    dir     = move_ok ? dir_sel : STOP;
  end

endmodule

// File: rtl/servo_track_sched.sv
// Two-axis tracker sequencer: request a sample, decide, move one servo for a
// bounded window, settle, repeat. All outputs are registered.
module servo_track_sched
  import servo_track_pkg::*;
#(
  parameter int ADC_W         = 12,
  parameter int DEADBAND      = 64,
  parameter int MOVE_CYCLES   = 2000000,
  parameter int SETTLE_CYCLES = 5000000,
  parameter int ADC_TIMEOUT   = 100000,
  parameter int POS_MIN       = DEF_POS_MIN,
  parameter int POS_MAX       = DEF_POS_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             track_en,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_top,
  input  logic [ADC_W-1:0] adc_bot,
  input  logic [ADC_W-1:0] adc_left,
  input  logic [ADC_W-1:0] adc_right,
  input  logic [31:0]      pos_h,
  input  logic [31:0]      pos_v,
  output logic             adc_req,
  output logic             h_cw,
  output logic             h_ccw,
  output logic             v_cw,
  output logic             v_ccw,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int MAX_A   = (MOVE_CYCLES > SETTLE_CYCLES) ? MOVE_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > ADC_TIMEOUT) ? MAX_A : ADC_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ADC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETL_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      PMIN      = 32'(POS_MIN);
  localparam logic [31:0]      PMAX      = 32'(POS_MAX);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             axis_reg, axis_next;
  dir_t             dir_reg, dir_next;
  logic             latch_en;

  logic [ADC_W-1:0] adc_in   [4];
  logic [ADC_W-1:0] samp_reg [4];

  logic             dec_axis;
  logic [1:0]       dec_dir;
  logic             dec_move_ok;
  logic [31:0]      pos_move;

  logic adc_req_reg, h_cw_reg, h_ccw_reg, v_cw_reg, v_ccw_reg, busy_reg;

  assign adc_in[0] = adc_top;
  assign adc_in[1] = adc_bot;
  assign adc_in[2] = adc_left;
  assign adc_in[3] = adc_right;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_samp
      always_ff @(posedge CLK) begin
        if (RST) begin
          samp_reg[gi] <= '0;
        end else if (latch_en) begin
          samp_reg[gi] <= adc_in[gi];
        end
      end
    end
  endgenerate

  track_decide #(
    .ADC_W    (ADC_W),
    .DEADBAND (DEADBAND),
    .POS_MIN  (PMIN),
    .POS_MAX  (PMAX)
  ) u_decide (
    .adc_top   (samp_reg[0]),
    .adc_bot   (samp_reg[1]),
    .adc_left  (samp_reg[2]),
    .adc_right (samp_reg[3]),
    .pos_h     (pos_h),
    .pos_v     (pos_v),
    .axis      (dec_axis),
    .dir       (dec_dir),
    .move_ok   (dec_move_ok)
  );

  assign pos_move = (axis_reg == AXIS_H) ? pos_h : pos_v;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    axis_next  = axis_reg;
    dir_next   = dir_reg;
    latch_en   = 1'b0;
    if (!track_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      dir_next   = STOP;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = REQ;
          cnt_next   = '0;
        end
        REQ: begin
          state_next = WAIT_ADC;
          cnt_next   = '0;
        end
        WAIT_ADC: begin
          if (adc_valid) begin
            latch_en   = 1'b1;
            state_next = DECIDE;
            cnt_next   = '0;
          end else if (cnt_reg == TO_LAST) begin
            state_next = REQ;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DECIDE: begin
          cnt_next = '0;
          if (dec_move_ok) begin
            state_next = MOVE;
            axis_next  = dec_axis;
            dir_next   = dir_t'(dec_dir);
          end else begin
            state_next = SETTLE;
            dir_next   = STOP;
          end
        end
        MOVE: begin
          // Position is re-checked every cycle so a servo never overdrives its end stop.
          if ((cnt_reg == MOVE_LAST) || at_limit(dir_reg, pos_move, PMIN, PMAX)) begin
            state_next = SETTLE;
            cnt_next   = '0;
            dir_next   = STOP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_reg == SETL_LAST) begin
            state_next = REQ;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      axis_reg    <= AXIS_H;
      dir_reg     <= STOP;
      adc_req_reg <= 1'b0;
      h_cw_reg    <= 1'b0;
      h_ccw_reg   <= 1'b0;
      v_cw_reg    <= 1'b0;
      v_ccw_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      axis_reg    <= axis_next;
      dir_reg     <= dir_next;
      adc_req_reg <= (state_next == REQ);
      // Outputs follow the next state so they line up with state_reg exactly.
      h_cw_reg    <= (state_next == MOVE) && (axis_next == AXIS_H) && (dir_next == CW);
      h_ccw_reg   <= (state_next == MOVE) && (axis_next == AXIS_H) && (dir_next == CCW);
      v_cw_reg    <= (state_next == MOVE) && (axis_next == AXIS_V) && (dir_next == CW);
      v_ccw_reg   <= (state_next == MOVE) && (axis_next == AXIS_V) && (dir_next == CCW);
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign adc_req   = adc_req_reg;
  assign h_cw      = h_cw_reg;
  assign h_ccw     = h_ccw_reg;
  assign v_cw      = v_cw_reg;
  assign v_ccw     = v_ccw_reg;
  assign busy      = busy_reg;
  assign state_dbg = state_reg;

endmodule
